// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Purpose  : ID/EX pipeline register and operand-select stage feeding the
//            32-bit ALU of the pipelined MIPS datapath. Registers decoded
//            instruction fields and the ALU-control decode. Forwards operands
//            from EX/MEM and MEM/WB. Converts load-use hazards into bubbles.
// Ports    :
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   id_*                       decoded instruction fields from ID
//   flush                      squash the instruction entering EX
//   ex_hold                    downstream stall, freeze this stage
//   mem_regwrite/rd/result     EX/MEM forwarding source
//   wb_regwrite/rd/result      MEM/WB forwarding source
//   stall                      ID/IF must hold this cycle
//   ex_valid                   EX holds a real instruction
//   alu_ctl/a/b/shamt          ALU Aluctl, A, B, shift_amount
//   ex_store_data              forwarded rt for stores
//   ex_dest, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
//                              control passed on to EX/MEM
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dest,
  input  logic [4:0]  id_shamt,
  input  logic [1:0]  id_aluop,
  input  logic [5:0]  id_funct,
  input  logic        id_alusrc,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic        flush,
  input  logic        ex_hold,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic        stall,
  output logic        ex_valid,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dest,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg
);

  // ALU control encodings understood by the downstream ALU.
  localparam logic [3:0] C_CTL_AND  = 4'd0;
  localparam logic [3:0] C_CTL_OR   = 4'd1;
  localparam logic [3:0] C_CTL_ADD  = 4'd2;
  localparam logic [3:0] C_CTL_SUB  = 4'd6;
  localparam logic [3:0] C_CTL_SLT  = 4'd7;
  localparam logic [3:0] C_CTL_SLL  = 4'd10;
  localparam logic [3:0] C_CTL_NOR  = 4'd12;
  localparam logic [3:0] C_CTL_NONE = 4'd15;

  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] C_ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] C_ALUOP_OR    = 2'b11;

  localparam logic [5:0] C_FN_ADD = 6'h20;
  localparam logic [5:0] C_FN_SUB = 6'h22;
  localparam logic [5:0] C_FN_AND = 6'h24;
  localparam logic [5:0] C_FN_OR  = 6'h25;
  localparam logic [5:0] C_FN_NOR = 6'h27;
  localparam logic [5:0] C_FN_SLT = 6'h2A;
  localparam logic [5:0] C_FN_SLL = 6'h00;

  // --------------------------------------------------------------------------
  // Pipeline register state
  // --------------------------------------------------------------------------
  logic        valid_q,    valid_d;
  logic [31:0] rs_data_q,  rs_data_d;
  logic [31:0] rt_data_q,  rt_data_d;
  logic [31:0] imm_q,      imm_d;
  logic [4:0]  rs_q,       rs_d;
  logic [4:0]  rt_q,       rt_d;
  logic [4:0]  dest_q,     dest_d;
  logic [4:0]  shamt_q,    shamt_d;
  logic        alusrc_q,   alusrc_d;
  logic        regwrite_q, regwrite_d;
  logic        memread_q,  memread_d;
  logic        memwrite_q, memwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic [3:0]  alu_ctl_q,  alu_ctl_d;

  logic [3:0]  w_alu_ctl_dec;
  logic        w_load_use;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  // --------------------------------------------------------------------------
  // ALU control decode of the instruction currently in ID
  // --------------------------------------------------------------------------
  always_comb begin
    w_alu_ctl_dec = C_CTL_NONE;
    case (id_aluop)
      C_ALUOP_ADD: w_alu_ctl_dec = C_CTL_ADD;
      C_ALUOP_SUB: w_alu_ctl_dec = C_CTL_SUB;
      C_ALUOP_OR:  w_alu_ctl_dec = C_CTL_OR;
      C_ALUOP_RTYPE: begin
        case (id_funct)
          C_FN_ADD: w_alu_ctl_dec = C_CTL_ADD;
          C_FN_SUB: w_alu_ctl_dec = C_CTL_SUB;
          C_FN_AND: w_alu_ctl_dec = C_CTL_AND;
          C_FN_OR:  w_alu_ctl_dec = C_CTL_OR;
          C_FN_NOR: w_alu_ctl_dec = C_CTL_NOR;
          C_FN_SLT: w_alu_ctl_dec = C_CTL_SLT;
          C_FN_SLL: w_alu_ctl_dec = C_CTL_SLL;
          default:  w_alu_ctl_dec = C_CTL_NONE;
        endcase
      end
      default: w_alu_ctl_dec = C_CTL_NONE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load-use hazard: a load in EX whose destination is read by ID. A flush
  // already squashes the ID instruction, so no stall is needed then.
  // --------------------------------------------------------------------------
  always_comb begin
    w_load_use = valid_q && memread_q && (dest_q != 5'd0) && id_valid &&
                 ((dest_q == id_rs) || (dest_q == id_rt)) && !flush;
  end

  assign stall = w_load_use | ex_hold;

  // --------------------------------------------------------------------------
  // Next-state selection: flush > hold > load-use bubble > capture
  // --------------------------------------------------------------------------
  always_comb begin
    valid_d    = valid_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    dest_d     = dest_q;
    shamt_d    = shamt_q;
    alusrc_d   = alusrc_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    alu_ctl_d  = alu_ctl_q;

    if (flush || (!ex_hold && w_load_use)) begin
      // Bubble: every field cleared so nothing stale can be forwarded later.
      valid_d    = 1'b0;
      rs_data_d  = 32'd0;
      rt_data_d  = 32'd0;
      imm_d      = 32'd0;
      rs_d       = 5'd0;
      rt_d       = 5'd0;
      dest_d     = 5'd0;
      shamt_d    = 5'd0;
      alusrc_d   = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      alu_ctl_d  = 4'd0;
    end else if (!ex_hold) begin
      valid_d    = id_valid;
      rs_data_d  = id_rs_data;
      rt_data_d  = id_rt_data;
      imm_d      = id_imm;
      rs_d       = id_rs;
      rt_d       = id_rt;
      dest_d     = id_dest;
      shamt_d    = id_shamt;
      alusrc_d   = id_alusrc;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
      memwrite_d = id_memwrite;
      memtoreg_d = id_memtoreg;
      alu_ctl_d  = w_alu_ctl_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rs_data_q  <= 32'd0;
      rt_data_q  <= 32'd0;
      imm_q      <= 32'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      dest_q     <= 5'd0;
      shamt_q    <= 5'd0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alu_ctl_q  <= 4'd0;
    end else begin
      valid_q    <= valid_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dest_q     <= dest_d;
      shamt_q    <= shamt_d;
      alusrc_q   <= alusrc_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      alu_ctl_q  <= alu_ctl_d;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding: the younger EX/MEM result wins over MEM/WB; $0 is hard-wired
  // to zero and must never pick up a forwarded value.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fwd_rs = rs_data_q;
    if (mem_regwrite && (mem_rd == rs_q) && (rs_q != 5'd0)) begin
      w_fwd_rs = mem_result;
    end else if (wb_regwrite && (wb_rd == rs_q) && (rs_q != 5'd0)) begin
      w_fwd_rs = wb_result;
    end
  end

  always_comb begin
    w_fwd_rt = rt_data_q;
    if (mem_regwrite && (mem_rd == rt_q) && (rt_q != 5'd0)) begin
      w_fwd_rt = mem_result;
    end else if (wb_regwrite && (wb_rd == rt_q) && (rt_q != 5'd0)) begin
      w_fwd_rt = wb_result;
    end
  end

  // --------------------------------------------------------------------------
  // Operand select; sll shifts rt, so rt is routed onto the A port.
  // --------------------------------------------------------------------------
  assign alu_a         = (alu_ctl_q == C_CTL_SLL) ? w_fwd_rt : w_fwd_rs;
  assign alu_b         = alusrc_q ? imm_q : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign alu_shamt     = shamt_q;
  assign alu_ctl       = alu_ctl_q;
  assign ex_valid      = valid_q;
  assign ex_dest       = dest_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_memtoreg   = memtoreg_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_stage
// Purpose  : Self-checking bench for ex_operand_stage. Directed scenarios
//            followed by randomized traffic, compared against a behavioural
//            model of the EX stage contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_dest, id_shamt;
  logic [1:0]  id_aluop;
  logic [5:0]  id_funct;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        flush, ex_hold;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        stall, ex_valid;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  alu_shamt, ex_dest;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_shamt(id_shamt),
    .id_aluop(id_aluop), .id_funct(id_funct), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .flush(flush), .ex_hold(ex_hold),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .stall(stall), .ex_valid(ex_valid), .alu_ctl(alu_ctl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
  );

  // Model of the instruction sitting in EX.
  typedef struct packed {
    bit        valid;
    bit [31:0] rs_data, rt_data, imm;
    bit [4:0]  rs, rt, dest, shamt;
    bit        alusrc, regwrite, memread, memwrite, memtoreg;
    bit [3:0]  ctl;
  } ex_t;

  ex_t m, m_nxt;
  bit  m_known = 1'b0;
  int  n_checks = 0;
  int  n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit [3:0] ref_ctl(input bit [1:0] op, input bit [5:0] fn);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (op == 2'd3) return 4'd1;
    case (fn)
      6'h20: return 4'd2;
      6'h22: return 4'd6;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h27: return 4'd12;
      6'h2A: return 4'd7;
      6'h00: return 4'd10;
      default: return 4'd15;
    endcase
  endfunction

  function automatic bit [31:0] ref_fwd(input bit [4:0] r, input bit [31:0] regval);
    if (r == 0) return regval;
    if (mem_regwrite && mem_rd == r) return mem_result;
    if (wb_regwrite && wb_rd == r) return wb_result;
    return regval;
  endfunction

  function automatic bit ref_load_use(input ex_t s);
    return s.valid && s.memread && s.dest != 0 && id_valid && !flush &&
           (s.dest == id_rs || s.dest == id_rt);
  endfunction

  function automatic ex_t ref_next(input ex_t s);
    ex_t n;
    n = '0;
    if (reset || flush) return n;
    if (ex_hold) return s;
    if (ref_load_use(s)) return n;
    n.valid = id_valid;     n.rs_data = id_rs_data; n.rt_data = id_rt_data;
    n.imm = id_imm;         n.rs = id_rs;           n.rt = id_rt;
    n.dest = id_dest;       n.shamt = id_shamt;     n.alusrc = id_alusrc;
    n.regwrite = id_regwrite; n.memread = id_memread;
    n.memwrite = id_memwrite; n.memtoreg = id_memtoreg;
    n.ctl = ref_ctl(id_aluop, id_funct);
    return n;
  endfunction

  task automatic check_all();
    bit [31:0] frs, frt;
    frs = ref_fwd(m.rs, m.rs_data);
    frt = ref_fwd(m.rt, m.rt_data);
    chk("stall", stall, ref_load_use(m) | ex_hold);
    chk("ex_valid", ex_valid, m.valid);
    chk("alu_ctl", alu_ctl, m.ctl);
    chk("alu_a", alu_a, (m.ctl == 4'd10) ? frt : frs);
    chk("alu_b", alu_b, m.alusrc ? m.imm : frt);
    chk("alu_shamt", alu_shamt, m.shamt);
    chk("store_data", ex_store_data, frt);
    chk("ex_dest", ex_dest, m.dest);
    chk("ex_regwrite", ex_regwrite, m.regwrite);
    chk("ex_memread", ex_memread, m.memread);
    chk("ex_memwrite", ex_memwrite, m.memwrite);
    chk("ex_memtoreg", ex_memtoreg, m.memtoreg);
  endtask

  // One clock: check settled outputs, advance the model across the edge,
  // return 1 time unit after the edge so callers can drive new inputs.
  task automatic cycle();
    @(negedge clk);
    if (m_known) check_all();
    m_nxt = ref_next(m);
    @(posedge clk);
    if (reset || m_known) begin
      m = m_nxt;
      m_known = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_dest = 0; id_shamt = 0; id_aluop = 0; id_funct = 0;
    id_alusrc = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    id_memtoreg = 0; flush = 0; ex_hold = 0;
    mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic rtype(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                       input bit [5:0] fn, input bit [31:0] rsd, input bit [31:0] rtd);
    id_valid = 1; id_aluop = 2'b10; id_funct = fn; id_rs = rs; id_rt = rt;
    id_dest = rd; id_rs_data = rsd; id_rt_data = rtd; id_alusrc = 0;
    id_regwrite = 1; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
  endtask

  task automatic randomize_inputs();
    reset = ($urandom_range(0, 99) < 3);
    flush = ($urandom_range(0, 99) < 8);
    ex_hold = ($urandom_range(0, 99) < 15);
    id_valid = ($urandom_range(0, 3) != 0);
    id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
    id_dest = 5'($urandom_range(0, 7)); id_shamt = 5'($urandom);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_aluop = 2'($urandom);
    case ($urandom_range(0, 7))
      0: id_funct = 6'h20; 1: id_funct = 6'h22; 2: id_funct = 6'h24;
      3: id_funct = 6'h25; 4: id_funct = 6'h27; 5: id_funct = 6'h2A;
      6: id_funct = 6'h00; default: id_funct = 6'($urandom);
    endcase
    id_alusrc = 1'($urandom); id_regwrite = 1'($urandom);
    id_memread = ($urandom_range(0, 2) == 0); id_memwrite = 1'($urandom);
    id_memtoreg = 1'($urandom);
    mem_regwrite = 1'($urandom); mem_rd = 5'($urandom_range(0, 7));
    mem_result = $urandom;
    wb_regwrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 7));
    wb_result = $urandom;
  endtask

  initial begin
    idle();
    // Reset for two cycles.
    reset = 1;
    cycle();
    cycle();
    reset = 0;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_alu_ctl", alu_ctl, 0);
    chk("rst_regwrite", ex_regwrite, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);

    // slt decode and capture.
    rtype(5'd1, 5'd2, 5'd3, 6'h2A, 32'd5, 32'd9);
    cycle();
    idle();
    #1;
    chk("slt_ctl", alu_ctl, 7);
    chk("slt_a", alu_a, 5);
    chk("slt_b", alu_b, 9);

    // sll routes rt onto A.
    rtype(5'd1, 5'd2, 5'd3, 6'h00, 32'd77, 32'd1);
    id_shamt = 5'd3;
    cycle();
    idle();
    #1;
    chk("sll_ctl", alu_ctl, 10);
    chk("sll_a", alu_a, 1);
    chk("sll_shamt", alu_shamt, 3);

    // Forwarding priority on rs=8.
    rtype(5'd8, 5'd9, 5'd3, 6'h20, 32'h55, 32'h66);
    cycle();
    idle();
    ex_hold = 1;
    mem_regwrite = 1; mem_rd = 8; mem_result = 32'h11;
    wb_regwrite = 1;  wb_rd = 8;  wb_result = 32'h22;
    #1;
    chk("fwd_mem_wins", alu_a, 32'h11);
    mem_regwrite = 0;
    #1;
    chk("fwd_wb", alu_a, 32'h22);
    cycle();
    idle();
    rtype(5'd0, 5'd9, 5'd3, 6'h20, 32'h77, 32'h66);
    cycle();
    idle();
    mem_regwrite = 1; mem_rd = 0; mem_result = 32'h99;
    wb_regwrite = 1;  wb_rd = 0;  wb_result = 32'h98;
    #1;
    chk("fwd_r0", alu_a, 32'h77);
    cycle();

    // Load-use: lw $4 in EX, dependent add in ID.
    idle();
    id_valid = 1; id_aluop = 2'b00; id_alusrc = 1; id_regwrite = 1;
    id_memread = 1; id_memtoreg = 1; id_dest = 5'd4; id_rs = 5'd1; id_imm = 32'h8;
    cycle();
    idle();
    rtype(5'd4, 5'd5, 5'd6, 6'h20, 32'h0BAD, 32'h3);
    #1;
    chk("lu_stall", stall, 1);
    cycle();
    mem_regwrite = 1; mem_rd = 4; mem_result = 32'h1111;
    #1;
    chk("lu_bubble", ex_valid, 0);
    chk("lu_stall_drop", stall, 0);
    cycle();
    id_valid = 0;
    mem_regwrite = 0;
    wb_regwrite = 1; wb_rd = 4; wb_result = 32'hCAFE;
    #1;
    chk("lu_captured", ex_valid, 1);
    chk("lu_fwd_wb", alu_a, 32'hCAFE);
    cycle();

    // Flush beats hold.
    idle();
    rtype(5'd1, 5'd2, 5'd3, 6'h22, 32'h10, 32'h4);
    cycle();
    idle();
    flush = 1; ex_hold = 1;
    cycle();
    idle();
    #1;
    chk("flush_hold", ex_valid, 0);

    // Hold alone for three cycles keeps the instruction.
    rtype(5'd1, 5'd2, 5'd3, 6'h24, 32'hF0, 32'h3C);
    cycle();
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      reset = 0; flush = 0; ex_hold = 1;
      mem_regwrite = 0; wb_regwrite = 0;
      #1;
      chk("hold_stall", stall, 1);
      chk("hold_valid", ex_valid, 1);
      chk("hold_ctl", alu_ctl, 0);
      chk("hold_a", alu_a, 32'hF0);
      cycle();
    end

    // Store data forwarded independent of alusrc.
    idle();
    id_valid = 1; id_aluop = 2'b00; id_alusrc = 1; id_memwrite = 1;
    id_rs = 5'd1; id_rt = 5'd6; id_rs_data = 32'h100; id_rt_data = 32'h1;
    id_imm = 32'h10;
    cycle();
    idle();
    mem_regwrite = 1; mem_rd = 6; mem_result = 32'hABCD;
    #1;
    chk("sw_alu_b", alu_b, 32'h10);
    chk("sw_store", ex_store_data, 32'hABCD);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
